// File: rtl/iob_ethoc_cfg_pkg.sv
// Shared definitions for the Ethernet MAC configuration sequencer:
// FSM states, MAC register word addresses, MODER bit fields and IPGT values.
package iob_ethoc_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  // MAC register word addresses
  localparam logic [7:0] ADDR_MODER      = 8'h00;
  localparam logic [7:0] ADDR_INT_SOURCE = 8'h01;
  localparam logic [7:0] ADDR_INT_MASK   = 8'h02;
  localparam logic [7:0] ADDR_IPGT       = 8'h03;
  localparam logic [7:0] ADDR_TX_BD_NUM  = 8'h08;
  localparam logic [7:0] ADDR_MAC_ADDR0  = 8'h10;
  localparam logic [7:0] ADDR_MAC_ADDR1  = 8'h11;

  // MODER bit fields
  localparam logic [31:0] MODER_RXEN    = 32'h0000_0001;
  localparam logic [31:0] MODER_TXEN    = 32'h0000_0002;
  localparam logic [31:0] MODER_LOOPBCK = 32'h0000_0080;
  localparam logic [31:0] MODER_FULLD   = 32'h0000_0400;
  localparam logic [31:0] MODER_CRCEN   = 32'h0000_2000;
  localparam logic [31:0] MODER_PAD     = 32'h0000_8000;

  // Back-to-back inter-packet gap for full / half duplex
  localparam logic [31:0] IPGT_FD = 32'h0000_0015;
  localparam logic [31:0] IPGT_HD = 32'h0000_0012;

  // Write-1-clear of every interrupt source
  localparam logic [31:0] INT_CLR_ALL = 32'h0000_007F;

  // Step indices with special handling
  localparam logic [3:0] STEP_READ = 4'd7;
  localparam logic [3:0] STEP_LAST = 4'd8;

  // MODER value with TX/RX still disabled: PAD and CRC always on
  function automatic logic [31:0] moder_base(input logic fd, input logic lb);
    return MODER_PAD | MODER_CRCEN
         | (lb ? MODER_LOOPBCK : 32'h0)
         | (fd ? MODER_FULLD : 32'h0);
  endfunction

endpackage

// File: rtl/iob_ethoc_cfg_seq.sv
// Ethernet MAC configuration sequencer. On an accepted start it issues a
// fixed list of native-bus register accesses to the MAC, checks the station
// address by readback, then enables TX/RX. Status is reported as busy/done/
// error levels plus the step index at which an abort happened.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset, waiting for start_i
// S_REQ  | valid_o high for step_q, waiting for ready_i or timeout
// S_GAP  | mandatory idle cycle between two accesses
// S_DONE | all steps completed, done_o held until next start
// S_ERR  | aborted (timeout or readback mismatch), error_o held
module iob_ethoc_cfg_seq
  import iob_ethoc_cfg_pkg::*;
#(
  parameter int          ADDR_W       = 12,
  parameter int          DATA_W       = 32,
  parameter int          TIMEOUT      = 1024,
  parameter logic [31:0] INT_MASK_VAL = 32'h0000_007F,
  parameter logic [31:0] TX_BD_VAL    = 32'h0000_0040
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [47:0]       mac_addr_i,
  input  logic              full_duplex_i,
  input  logic              loopback_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [3:0]        err_step_o
);

  // Wait counter counts down from TIMEOUT-1; reaching zero without ready_i
  // means valid_o has been held for exactly TIMEOUT cycles.
  localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       err_step_q, err_step_d;
  logic             cfg_load;
  logic [47:0]      mac_q;
  logic             fd_q;
  logic             lb_q;

  logic [7:0]       step_addr;
  logic [31:0]      step_data;
  logic             step_rd;
  logic [31:0]      moder_b;

  assign moder_b = moder_base(fd_q, lb_q);

  // Step table: register, data and direction for the current step
  always_comb begin
    step_addr = ADDR_MODER;
    step_data = 32'h0;
    step_rd   = 1'b0;
    case (step_q)
      4'd0: begin step_addr = ADDR_MODER;      step_data = moder_b;                    end
      4'd1: begin step_addr = ADDR_INT_SOURCE; step_data = INT_CLR_ALL;                end
      4'd2: begin step_addr = ADDR_INT_MASK;   step_data = INT_MASK_VAL;               end
      4'd3: begin step_addr = ADDR_IPGT;       step_data = fd_q ? IPGT_FD : IPGT_HD;   end
      4'd4: begin step_addr = ADDR_TX_BD_NUM;  step_data = TX_BD_VAL;                  end
      4'd5: begin step_addr = ADDR_MAC_ADDR0;  step_data = mac_q[31:0];                end
      4'd6: begin step_addr = ADDR_MAC_ADDR1;  step_data = {16'h0, mac_q[47:32]};      end
      4'd7: begin step_addr = ADDR_MAC_ADDR0;  step_rd   = 1'b1;                       end
      4'd8: begin step_addr = ADDR_MODER;      step_data = moder_b | MODER_RXEN | MODER_TXEN; end
      default: begin step_addr = ADDR_MODER;   step_data = 32'h0;                      end
    endcase
  end

  // Next-state logic: sequencing, timeout and readback abort
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    err_step_d = err_step_q;
    cfg_load   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_REQ;
          step_d     = 4'd0;
          cnt_d      = CNT_LOAD;
          err_step_d = 4'd0;
          cfg_load   = 1'b1;
        end
      end
      S_REQ: begin
        if (ready_i) begin
          if (step_rd && (rdata_i[31:0] != mac_q[31:0])) begin
            state_d    = S_ERR;
            err_step_d = step_q;
          end else if (step_q == STEP_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
            step_d  = step_q + 4'd1;
          end
        end else if (cnt_q == '0) begin
          state_d    = S_ERR;
          err_step_d = step_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_REQ;
        cnt_d   = CNT_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and configuration captured at an accepted start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      step_q     <= 4'd0;
      cnt_q      <= '0;
      err_step_q <= 4'd0;
      mac_q      <= 48'h0;
      fd_q       <= 1'b0;
      lb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      err_step_q <= err_step_d;
      if (cfg_load) begin
        mac_q <= mac_addr_i;
        fd_q  <= full_duplex_i;
        lb_q  <= loopback_i;
      end
    end
  end

  // Bus outputs are driven from the step table only while requesting, so
  // they stay constant for the whole valid_o period and are zero otherwise.
  always_comb begin
    valid_o   = (state_q == S_REQ);
    address_o = '0;
    wdata_o   = '0;
    wstrb_o   = 4'h0;
    if (valid_o) begin
      address_o = ADDR_W'(step_addr);
      if (!step_rd) begin
        wdata_o = DATA_W'(step_data);
        wstrb_o = 4'hF;
      end
    end
  end

  assign busy_o     = (state_q == S_REQ) || (state_q == S_GAP);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERR);
  assign err_step_o = err_step_q;

endmodule
